vrf_access_ctrl: RTL and testbench



---
 rtl/vrf_access_ctrl_if.sv | 67 ++++++
 rtl/vrf_access_ctrl.sv | 137 +++++++++++++
 tb/tb_vrf_access_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vrf_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : vrf_access_ctrl_if
//  Purpose  : Bundles the requester-side write/read/response channels and the
//             VRF-side write/read port of vrf_access_ctrl.
//  Modports : master - functional units plus VRF storage (environment side)
//             slave  - vrf_access_ctrl (controller side)
//  Signals  : wr_valid/wr_ready/wr_addr/wr_data/wr_be   write requests
//             rd_valid/rd_ready/rd_addr                  read requests
//             rsp_valid/rsp_ready/rsp_data               read responses
//             vrf_we/vrf_waddr/vrf_wdata/vrf_wbe         VRF write port
//             vrf_raddr/vrf_rdata                        VRF read ports
//  Revision : 1.0 - initial release
// ============================================================================
interface vrf_access_ctrl_if #(
    parameter int unsigned NrReadPorts  = 3,
    parameter int unsigned NrWritePorts = 2,
    parameter int unsigned NrWords      = 32,
    parameter int unsigned WordWidth    = 32
);
    localparam int unsigned c_ADDR_W = (NrWords > 1) ? $clog2(NrWords) : 1;
    localparam int unsigned c_NB     = WordWidth / 8;

    logic [NrWritePorts-1:0]                wr_valid;
    logic [NrWritePorts-1:0]                wr_ready;
    logic [NrWritePorts-1:0][c_ADDR_W-1:0]  wr_addr;
    logic [NrWritePorts-1:0][WordWidth-1:0] wr_data;
    logic [NrWritePorts-1:0][c_NB-1:0]      wr_be;

    logic [NrReadPorts-1:0]                 rd_valid;
    logic [NrReadPorts-1:0]                 rd_ready;
    logic [NrReadPorts-1:0][c_ADDR_W-1:0]   rd_addr;

    logic [NrReadPorts-1:0]                 rsp_valid;
    logic [NrReadPorts-1:0]                 rsp_ready;
    logic [NrReadPorts-1:0][WordWidth-1:0]  rsp_data;

    logic [c_ADDR_W-1:0]                    vrf_waddr;
    logic [WordWidth-1:0]                   vrf_wdata;
    logic                                   vrf_we;
    logic [c_NB-1:0]                        vrf_wbe;
    logic [NrReadPorts-1:0][c_ADDR_W-1:0]   vrf_raddr;
    logic [NrReadPorts-1:0][WordWidth-1:0]  vrf_rdata;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be,
        input  wr_ready,
        output rd_valid, rd_addr,
        input  rd_ready,
        input  rsp_valid, rsp_data,
        output rsp_ready,
        input  vrf_waddr, vrf_wdata, vrf_we, vrf_wbe, vrf_raddr,
        output vrf_rdata
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be,
        output wr_ready,
        input  rd_valid, rd_addr,
        output rd_ready,
        output rsp_valid, rsp_data,
        input  rsp_ready,
        output vrf_waddr, vrf_wdata, vrf_we, vrf_wbe, vrf_raddr,
        input  vrf_rdata
    );
endinterface
`default_nettype wire

// File: rtl/vrf_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vrf_access_ctrl
//  Purpose  : Initiator-side VRF access controller. Round-robin arbitrates
//             the write requesters onto the single VRF write port and gives
//             every read requester a registered, back-pressurable response
//             with write-first forwarding (uniform 1-cycle read latency).
//  Ports    : clk_i   - clock
//             rst_ni  - asynchronous active-low reset
//             bus     - vrf_access_ctrl_if.slave (requests, responses, VRF)
//  Revision : 1.0 - initial release
// ============================================================================
module vrf_access_ctrl #(
    parameter int unsigned NrReadPorts  = 3,
    parameter int unsigned NrWritePorts = 2,
    parameter int unsigned NrWords      = 32,
    parameter int unsigned WordWidth    = 32
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    vrf_access_ctrl_if.slave   bus
);
    localparam int unsigned c_ADDR_W = (NrWords > 1) ? $clog2(NrWords) : 1;
    localparam int unsigned c_NB     = WordWidth / 8;
    localparam int unsigned c_RR_W   = (NrWritePorts > 1) ? $clog2(NrWritePorts) : 1;
    localparam logic [c_RR_W-1:0] c_RR_LAST = c_RR_W'(NrWritePorts - 1);

    // ------------------------------------------------------------------
    // Write arbitration
    // ------------------------------------------------------------------
    logic [c_RR_W-1:0]        r_rr;
    logic                     w_gnt_found;
    logic [c_RR_W-1:0]        w_gnt_idx;
    int unsigned              w_cand;
    logic                     w_we;
    logic [NrWritePorts-1:0]  w_wr_ready;
    logic [c_ADDR_W-1:0]      w_waddr;
    logic [WordWidth-1:0]     w_wdata;
    logic [c_NB-1:0]          w_wbe;

    // First valid requester found when scanning upward from r_rr, wrapping.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_cand      = 0;
        for (int unsigned k = 0; k < NrWritePorts; k++) begin
            w_cand = (32'(r_rr) + k) % NrWritePorts;
            if (!w_gnt_found && bus.wr_valid[c_RR_W'(w_cand)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = c_RR_W'(w_cand);
            end
        end
    end

    // Gating with rst_ni keeps the write port quiet while reset is held, so
    // nothing half-granted reaches the VRF around reset release.
    assign w_we = w_gnt_found & rst_ni;

    always_comb begin
        w_wr_ready = '0;
        w_waddr    = '0;
        w_wdata    = '0;
        w_wbe      = '0;
        if (w_we) begin
            w_wr_ready[w_gnt_idx] = 1'b1;
            w_waddr               = bus.wr_addr[w_gnt_idx];
            w_wdata               = bus.wr_data[w_gnt_idx];
            w_wbe                 = bus.wr_be[w_gnt_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= '0;
        end else if (w_we) begin
            r_rr <= (w_gnt_idx == c_RR_LAST) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [NrReadPorts-1:0]                r_rsp_valid;
    logic [NrReadPorts-1:0][WordWidth-1:0] r_rsp_data;
    logic [NrReadPorts-1:0]                w_rd_ready;
    logic [NrReadPorts-1:0]                w_rd_accept;
    logic [NrReadPorts-1:0][WordWidth-1:0] w_merge;

    always_comb begin
        w_rd_ready  = '0;
        w_rd_accept = '0;
        w_merge     = '0;
        for (int p = 0; p < NrReadPorts; p++) begin
            // Slot is free when empty or being drained this cycle.
            w_rd_ready[p]  = rst_ni & (~r_rsp_valid[p] | bus.rsp_ready[p]);
            w_rd_accept[p] = bus.rd_valid[p] & w_rd_ready[p];
            // The VRF only shows this cycle's write after the edge, so
            // enabled bytes of a same-address write are forwarded here.
            w_merge[p]     = bus.vrf_rdata[p];
            for (int b = 0; b < c_NB; b++) begin
                if (w_we && (w_waddr == bus.rd_addr[p]) && w_wbe[b]) begin
                    w_merge[p][8*b +: 8] = w_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            for (int p = 0; p < NrReadPorts; p++) begin
                if (w_rd_accept[p]) begin
                    r_rsp_valid[p] <= 1'b1;
                    r_rsp_data[p]  <= w_merge[p];
                end else if (bus.rsp_ready[p]) begin
                    r_rsp_valid[p] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wr_ready  = w_wr_ready;
    assign bus.vrf_we    = w_we;
    assign bus.vrf_waddr = w_waddr;
    assign bus.vrf_wdata = w_wdata;
    assign bus.vrf_wbe   = w_wbe;
    assign bus.vrf_raddr = bus.rd_addr;
    assign bus.rd_ready  = w_rd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
endmodule
`default_nettype wire

// File: tb/tb_vrf_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vrf_access_ctrl
//  Purpose  : Self-checking bench for vrf_access_ctrl: directed vector table,
//             hand-written back-pressure and reset sequences, and random
//             traffic checked against a word-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vrf_access_ctrl;
    localparam int NRP = 3;
    localparam int NWP = 2;
    localparam int NW  = 32;
    localparam int WW  = 32;
    localparam int NB  = WW / 8;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    vrf_access_ctrl_if #(.NrReadPorts(NRP), .NrWritePorts(NWP),
                         .NrWords(NW), .WordWidth(WW)) bus ();

    vrf_access_ctrl #(.NrReadPorts(NRP), .NrWritePorts(NWP),
                      .NrWords(NW), .WordWidth(WW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // VRF storage: combinational read, byte-enabled write at the clock edge.
    logic [WW-1:0] mem [NW];
    initial begin
        for (int i = 0; i < NW; i++) mem[i] = '0;
        forever begin
            @(posedge clk_i);
            if (bus.vrf_we)
                for (int b = 0; b < NB; b++)
                    if (bus.vrf_wbe[b])
                        mem[bus.vrf_waddr][8*b +: 8] <= bus.vrf_wdata[8*b +: 8];
        end
    end
    always_comb begin
        for (int p = 0; p < NRP; p++) bus.vrf_rdata[p] = mem[bus.vrf_raddr[p]];
    end

    // Reference model state
    logic [WW-1:0]  ref_mem [NW];
    int             ref_ptr;
    logic [NRP-1:0] exp_valid;
    logic [WW-1:0]  exp_data [NRP];
    int             n_checks = 0;
    int             n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] byte_mix(input logic [WW-1:0] old_w,
                                               input logic [WW-1:0] new_w,
                                               input logic [NB-1:0] be);
        logic [WW-1:0] mask;
        mask = '0;
        for (int b = 0; b < NB; b++) if (be[b]) mask[8*b +: 8] = 8'hFF;
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // Called at mid-cycle with inputs stable: checks every output against the
    // model, crosses the clock edge, advances the model, returns at edge+1.
    task automatic model_step();
        int             gi;
        int             idx;
        logic [NWP-1:0] exp_wr;
        logic [NRP-1:0] acc;
        logic [NRP-1:0] rr;
        logic [WW-1:0]  nd [NRP];
        logic [4:0]     wa;
        logic [WW-1:0]  wd;
        logic [NB-1:0]  wb;
        logic           rdy;
        gi = -1;
        for (int k = 0; k < NWP; k++) begin
            idx = (ref_ptr + k) % NWP;
            if (gi < 0 && bus.wr_valid[idx]) gi = idx;
        end
        exp_wr = '0;
        wa = '0; wd = '0; wb = '0;
        if (gi >= 0) begin
            exp_wr[gi] = 1'b1;
            wa = bus.wr_addr[gi]; wd = bus.wr_data[gi]; wb = bus.wr_be[gi];
        end
        check("wr_ready", bus.wr_ready, exp_wr);
        check("vrf_we", bus.vrf_we, gi >= 0);
        check("vrf_waddr", bus.vrf_waddr, wa);
        check("vrf_wdata", bus.vrf_wdata, wd);
        check("vrf_wbe", bus.vrf_wbe, wb);
        for (int p = 0; p < NRP; p++) begin
            rdy = !exp_valid[p] || bus.rsp_ready[p];
            check($sformatf("rd_ready[%0d]", p), bus.rd_ready[p], rdy);
            check($sformatf("rsp_valid[%0d]", p), bus.rsp_valid[p], exp_valid[p]);
            if (exp_valid[p])
                check($sformatf("rsp_data[%0d]", p), bus.rsp_data[p], exp_data[p]);
            check($sformatf("vrf_raddr[%0d]", p), bus.vrf_raddr[p], bus.rd_addr[p]);
            acc[p] = bus.rd_valid[p] && rdy;
            rr[p]  = bus.rsp_ready[p];
            nd[p]  = ref_mem[bus.rd_addr[p]];
            if (gi >= 0 && wa == bus.rd_addr[p]) nd[p] = byte_mix(nd[p], wd, wb);
        end
        @(posedge clk_i);
        if (gi >= 0) begin
            ref_mem[wa] = byte_mix(ref_mem[wa], wd, wb);
            ref_ptr     = (gi + 1) % NWP;
        end
        for (int p = 0; p < NRP; p++) begin
            if (acc[p]) begin
                exp_valid[p] = 1'b1;
                exp_data[p]  = nd[p];
            end else if (rr[p]) begin
                exp_valid[p] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic drive_idle();
        bus.wr_valid  = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_be     = '0;
        bus.rd_valid  = '0;
        bus.rd_addr   = '0;
        bus.rsp_ready = '1;
    endtask

    typedef struct {
        logic [1:0]  wv;
        logic [4:0]  wa0; logic [31:0] wd0; logic [3:0] wb0;
        logic [4:0]  wa1; logic [31:0] wd1; logic [3:0] wb1;
        logic        rv;  logic [4:0]  ra;
        logic [1:0]  ewr; logic        ev;  logic [31:0] ed;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] wv,
                                input logic [4:0] wa0, input logic [31:0] wd0, input logic [3:0] wb0,
                                input logic [4:0] wa1, input logic [31:0] wd1, input logic [3:0] wb1,
                                input logic rv, input logic [4:0] ra,
                                input logic [1:0] ewr, input logic ev, input logic [31:0] ed);
        return '{wv, wa0, wd0, wb0, wa1, wd1, wb1, rv, ra, ewr, ev, ed};
    endfunction

    vec_t tbl [24];

    initial begin
        // write / read-back, forwarding, alternation, single requester, zero-BE
        tbl[0]  = mk(2'b01, 5, 32'hA5A5A5A5, 4'hF, 0, 0, 0,            0, 0, 2'b01, 0, 0);
        tbl[1]  = mk(2'b00, 0, 0, 0,             0, 0, 0,              1, 5, 2'b00, 0, 0);
        tbl[2]  = mk(2'b00, 0, 0, 0,             0, 0, 0,              0, 0, 2'b00, 1, 32'hA5A5A5A5);
        tbl[3]  = mk(2'b10, 0, 0, 0,             3, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 0, 0);
        tbl[4]  = mk(2'b01, 3, 32'h11223344, 4'h5, 0, 0, 0,            1, 3, 2'b01, 0, 0);
        tbl[5]  = mk(2'b00, 0, 0, 0,             0, 0, 0,              0, 0, 2'b00, 1, 32'hFF22FF44);
        tbl[6]  = mk(2'b10, 0, 0, 0,             9, 32'h99, 4'hF,      0, 0, 2'b10, 0, 0);
        tbl[7]  = mk(2'b11, 10, 32'hA0, 4'hF,    20, 32'hB0, 4'hF,     0, 0, 2'b01, 0, 0);
        tbl[8]  = mk(2'b11, 11, 32'hA1, 4'hF,    20, 32'hB0, 4'hF,     0, 0, 2'b10, 0, 0);
        tbl[9]  = mk(2'b11, 11, 32'hA1, 4'hF,    21, 32'hB1, 4'hF,     0, 0, 2'b01, 0, 0);
        tbl[10] = mk(2'b11, 12, 32'hA2, 4'hF,    21, 32'hB1, 4'hF,     0, 0, 2'b10, 0, 0);
        tbl[11] = mk(2'b00, 0, 0, 0,             0, 0, 0,              1, 10, 2'b00, 0, 0);
        tbl[12] = mk(2'b00, 0, 0, 0,             0, 0, 0,              1, 20, 2'b00, 1, 32'hA0);
        tbl[13] = mk(2'b00, 0, 0, 0,             0, 0, 0,              1, 11, 2'b00, 1, 32'hB0);
        tbl[14] = mk(2'b00, 0, 0, 0,             0, 0, 0,              1, 21, 2'b00, 1, 32'hA1);
        tbl[15] = mk(2'b00, 0, 0, 0,             0, 0, 0,              0, 0, 2'b00, 1, 32'hB1);
        tbl[16] = mk(2'b10, 0, 0, 0,             22, 32'hC0, 4'hF,     0, 0, 2'b10, 0, 0);
        tbl[17] = mk(2'b10, 0, 0, 0,             22, 32'hC1, 4'hF,     0, 0, 2'b10, 0, 0);
        tbl[18] = mk(2'b10, 0, 0, 0,             22, 32'hC2, 4'hF,     0, 0, 2'b10, 0, 0);
        tbl[19] = mk(2'b01, 7, 32'h77777777, 4'hF, 0, 0, 0,            0, 0, 2'b01, 0, 0);
        tbl[20] = mk(2'b10, 0, 0, 0,             7, 32'hDEADBEEF, 4'h0, 1, 7, 2'b10, 0, 0);
        tbl[21] = mk(2'b00, 0, 0, 0,             0, 0, 0,              1, 7, 2'b00, 1, 32'h77777777);
        tbl[22] = mk(2'b00, 0, 0, 0,             0, 0, 0,              0, 0, 2'b00, 1, 32'h77777777);
        tbl[23] = mk(2'b00, 0, 0, 0,             0, 0, 0,              0, 0, 2'b00, 0, 0);

        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        ref_ptr   = 0;
        exp_valid = '0;
        for (int p = 0; p < NRP; p++) exp_data[p] = '0;
        drive_idle();

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk_i);
        #1;
        check("reset rsp_valid", bus.rsp_valid, 0);
        check("reset wr_ready", bus.wr_ready, 0);
        check("reset vrf_we", bus.vrf_we, 0);
        check("reset rsp_data0", bus.rsp_data[0], 0);
        rst_ni = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 24; i++) begin
            drive_idle();
            bus.wr_valid   = tbl[i].wv;
            bus.wr_addr[0] = tbl[i].wa0; bus.wr_data[0] = tbl[i].wd0; bus.wr_be[0] = tbl[i].wb0;
            bus.wr_addr[1] = tbl[i].wa1; bus.wr_data[1] = tbl[i].wd1; bus.wr_be[1] = tbl[i].wb1;
            bus.rd_valid[0] = tbl[i].rv;
            bus.rd_addr[0]  = tbl[i].ra;
            #4;
            check($sformatf("tbl%0d wr_ready", i), bus.wr_ready, tbl[i].ewr);
            check($sformatf("tbl%0d rsp_valid0", i), bus.rsp_valid[0], tbl[i].ev);
            if (tbl[i].ev)
                check($sformatf("tbl%0d rsp_data0", i), bus.rsp_data[0], tbl[i].ed);
            model_step();
        end

        // ---------------- back-pressure on read port 1 ----------------
        drive_idle();
        bus.rd_valid[1] = 1'b1; bus.rd_addr[1] = 5;
        #4;
        check("bp accept rd_ready1", bus.rd_ready[1], 1);
        model_step();
        for (int j = 0; j < 3; j++) begin
            drive_idle();
            bus.rsp_ready[1] = 1'b0;
            bus.rd_valid[1]  = 1'b1; bus.rd_addr[1] = 3;
            if (j == 0) begin
                bus.wr_valid = 2'b01; bus.wr_addr[0] = 5;
                bus.wr_data[0] = 32'h5A5A5A5A; bus.wr_be[0] = 4'hF;
            end
            #4;
            check($sformatf("bp%0d rd_ready1", j), bus.rd_ready[1], 0);
            check($sformatf("bp%0d rsp_valid1", j), bus.rsp_valid[1], 1);
            check($sformatf("bp%0d rsp_data1", j), bus.rsp_data[1], 32'hA5A5A5A5);
            model_step();
        end
        drive_idle();
        bus.rd_valid[1] = 1'b1; bus.rd_addr[1] = 3;
        #4;
        check("bp release rd_ready1", bus.rd_ready[1], 1);
        check("bp release rsp_data1", bus.rsp_data[1], 32'hA5A5A5A5);
        model_step();
        drive_idle();
        #4;
        check("bp next rsp_valid1", bus.rsp_valid[1], 1);
        check("bp next rsp_data1", bus.rsp_data[1], 32'hFF22FF44);
        model_step();
        drive_idle();
        #4;
        check("bp drained rsp_valid1", bus.rsp_valid[1], 0);
        model_step();

        // ---------------- mid-operation reset ----------------
        drive_idle();
        bus.rsp_ready = '0;
        bus.rd_valid  = 3'b101; bus.rd_addr[0] = 5; bus.rd_addr[2] = 5;
        #4;
        model_step();
        drive_idle();
        bus.rsp_ready = '0;
        bus.wr_valid  = 2'b11;
        bus.wr_addr[0] = 1; bus.wr_data[0] = 32'h01010101; bus.wr_be[0] = 4'hF;
        bus.wr_addr[1] = 2; bus.wr_data[1] = 32'h02020202; bus.wr_be[1] = 4'hF;
        #2;
        check("pre-reset rsp_valid", bus.rsp_valid, 3'b101);
        rst_ni = 1'b0;
        #1;
        check("mid reset rsp_valid", bus.rsp_valid, 0);
        check("mid reset wr_ready", bus.wr_ready, 0);
        check("mid reset vrf_we", bus.vrf_we, 0);
        exp_valid = '0;
        ref_ptr   = 0;
        for (int p = 0; p < NRP; p++) exp_data[p] = '0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        bus.rsp_ready = '1;
        #4;
        check("post reset first grant", bus.wr_ready, 2'b01);
        model_step();

        // ---------------- random traffic ----------------
        for (int c = 0; c < 400; c++) begin
            bus.wr_valid = 2'($urandom);
            for (int k = 0; k < NWP; k++) begin
                bus.wr_addr[k] = 5'($urandom_range(0, 7));
                bus.wr_data[k] = $urandom;
                bus.wr_be[k]   = 4'($urandom);
            end
            bus.rd_valid = 3'($urandom);
            for (int p = 0; p < NRP; p++) begin
                bus.rd_addr[p]   = 5'($urandom_range(0, 7));
                bus.rsp_ready[p] = ($urandom_range(0, 3) != 0);
            end
            #4;
            model_step();
        end

        drive_idle();
        #4;
        model_step();
        for (int i = 0; i < NW; i++)
            check($sformatf("vrf word %0d", i), mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
